// File: rtl/tensor_wb_buffer.sv
// Writeback buffer behind the BF16 tensor MAC: pairs in-order MAC results with issue tags and drains them over valid/ready.
// Optional performance counters are enabled by defining TENSOR_WB_PERF_EN.
`default_nettype none

module tensor_wb_buffer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_en,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             issue_ready,
    input  logic             res_valid,
    input  logic [63:0]      res_data,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [63:0]      wb_data,
    output logic [3:0]       wb_lane_mask,
    output logic             busy,
    output logic             err,
    input  logic             perf_clr,
    output logic [31:0]      perf_wb_cnt,
    output logic [31:0]      perf_stall_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);

    // Lane is nonzero when any exponent/mantissa bit is set; the sign bit is ignored so -0.0 reads as zero.
    function automatic logic [3:0] lane_nonzero(input logic [63:0] d);
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            m[i] = |d[16*i +: 15];
        end
        return m;
    endfunction

    logic [PTR_W-1:0] iss_ptr_q, iss_ptr_d;
    logic [PTR_W-1:0] res_ptr_q, res_ptr_d;
    logic [PTR_W-1:0] wb_ptr_q, wb_ptr_d;
    logic             err_q, err_d;

    logic [TAG_W-1:0] tag_mem_q  [DEPTH];
    logic [63:0]      data_mem_q [DEPTH];
    logic [3:0]       mask_mem_q [DEPTH];

    logic [PTR_W-1:0] occ_s, outst_s, rdy_s;
    logic             do_issue_s, do_cap_s, do_pop_s;
    logic             bad_issue_s, stray_s;
    logic [IDX_W-1:0] iss_idx_s, res_idx_s, wb_idx_s;

    assign occ_s     = iss_ptr_q - wb_ptr_q;
    assign outst_s   = iss_ptr_q - res_ptr_q;
    assign rdy_s     = res_ptr_q - wb_ptr_q;
    assign iss_idx_s = iss_ptr_q[IDX_W-1:0];
    assign res_idx_s = res_ptr_q[IDX_W-1:0];
    assign wb_idx_s  = wb_ptr_q[IDX_W-1:0];

    // Event decode: issue, capture and pop act on independent pointers.
    always_comb begin
        issue_ready = (occ_s != PTR_DEPTH);
        wb_valid    = (rdy_s != PTR_ZERO);
        busy        = (occ_s != PTR_ZERO);
        do_issue_s  = issue_en && issue_ready;
        bad_issue_s = issue_en && !issue_ready;
        do_cap_s    = res_valid && (outst_s != PTR_ZERO);
        stray_s     = res_valid && (outst_s == PTR_ZERO);
        do_pop_s    = wb_valid && wb_ready;
    end

    // Next-state for pointers and the sticky error flag.
    always_comb begin
        iss_ptr_d = iss_ptr_q;
        res_ptr_d = res_ptr_q;
        wb_ptr_d  = wb_ptr_q;
        err_d     = err_q;
        if (do_issue_s) begin
            iss_ptr_d = iss_ptr_q + PTR_ONE;
        end else begin
            iss_ptr_d = iss_ptr_q;
        end
        if (do_cap_s) begin
            res_ptr_d = res_ptr_q + PTR_ONE;
        end else begin
            res_ptr_d = res_ptr_q;
        end
        if (do_pop_s) begin
            wb_ptr_d = wb_ptr_q + PTR_ONE;
        end else begin
            wb_ptr_d = wb_ptr_q;
        end
        if (bad_issue_s || stray_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Pointer and error state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_ptr_q <= PTR_ZERO;
            res_ptr_q <= PTR_ZERO;
            wb_ptr_q  <= PTR_ZERO;
            err_q     <= 1'b0;
        end else begin
            iss_ptr_q <= iss_ptr_d;
            res_ptr_q <= res_ptr_d;
            wb_ptr_q  <= wb_ptr_d;
            err_q     <= err_d;
        end
    end

    // Entry storage needs no reset: only slots between wb_ptr and res_ptr are ever presented.
    always_ff @(posedge clk) begin
        if (do_issue_s) begin
            tag_mem_q[iss_idx_s] <= issue_tag;
        end
        if (do_cap_s) begin
            data_mem_q[res_idx_s] <= res_data;
            mask_mem_q[res_idx_s] <= lane_nonzero(res_data);
        end
    end

    // Head entry presentation, forced to zero while nothing is ready.
    always_comb begin
        if (wb_valid) begin
            wb_tag       = tag_mem_q[wb_idx_s];
            wb_data      = data_mem_q[wb_idx_s];
            wb_lane_mask = mask_mem_q[wb_idx_s];
        end else begin
            wb_tag       = {TAG_W{1'b0}};
            wb_data      = 64'h0;
            wb_lane_mask = 4'b0000;
        end
    end

    assign err = err_q;

`ifdef TENSOR_WB_PERF_EN
    logic [31:0] perf_wb_q, perf_wb_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating counters; a clear beats an increment in the same cycle.
    always_comb begin
        perf_wb_d    = perf_wb_q;
        perf_stall_d = perf_stall_q;
        if (perf_clr) begin
            perf_wb_d    = 32'h0;
            perf_stall_d = 32'h0;
        end else begin
            if (do_pop_s && (perf_wb_q != 32'hFFFF_FFFF)) begin
                perf_wb_d = perf_wb_q + 32'h1;
            end else begin
                perf_wb_d = perf_wb_q;
            end
            if (wb_valid && !wb_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_d = perf_stall_q + 32'h1;
            end else begin
                perf_stall_d = perf_stall_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_wb_q    <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            perf_wb_q    <= perf_wb_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_wb_cnt    = perf_wb_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    logic perf_clr_unused_s;
    assign perf_clr_unused_s = perf_clr;
    assign perf_wb_cnt       = 32'h0;
    assign perf_stall_cnt    = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tensor_wb_buffer.sv
// Scoreboard bench for tensor_wb_buffer: directed issue/result vectors push expected writebacks, a negedge monitor checks pops.
module tb_tensor_wb_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_en;
    logic [4:0]  issue_tag;
    logic        issue_ready;
    logic        res_valid;
    logic [63:0] res_data;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_tag;
    logic [63:0] wb_data;
    logic [3:0]  wb_lane_mask;
    logic        busy;
    logic        err;
    logic        perf_clr;
    logic [31:0] perf_wb_cnt;
    logic [31:0] perf_stall_cnt;

    typedef struct packed {
        logic [4:0]  tag;
        logic [63:0] data;
        logic [3:0]  mask;
    } exp_t;

    exp_t       sb_q[$];
    logic [4:0] tq[$];
    exp_t       mon_e;
    int         n_chk  = 0;
    int         n_fail = 0;

    tensor_wb_buffer #(.DEPTH(4), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_en(issue_en), .issue_tag(issue_tag), .issue_ready(issue_ready),
        .res_valid(res_valid), .res_data(res_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
        .wb_data(wb_data), .wb_lane_mask(wb_lane_mask),
        .busy(busy), .err(err), .perf_clr(perf_clr),
        .perf_wb_cnt(perf_wb_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_en  = 1'b0;
        issue_tag = 5'd0;
        res_valid = 1'b0;
        res_data  = 64'h0;
    endtask

    task automatic issue(input logic [4:0] t);
        issue_en  = 1'b1;
        issue_tag = t;
        tq.push_back(t);
    endtask

    task automatic result(input logic [63:0] d, input logic [3:0] m);
        exp_t e;
        e.tag  = (tq.size() != 0) ? tq.pop_front() : 5'd0;
        e.data = d;
        e.mask = m;
        sb_q.push_back(e);
        res_valid = 1'b1;
        res_data  = d;
    endtask

    task automatic do_reset();
        idle();
        wb_ready = 1'b0;
        perf_clr = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        chk("rst_issue_ready", 64'(issue_ready), 64'h1);
        chk("rst_wb_valid", 64'(wb_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_wb_data", wb_data, 64'h0);
        chk("rst_wb_tag", 64'(wb_tag), 64'h0);
        chk("rst_perf_wb", 64'(perf_wb_cnt), 64'h0);
        sb_q.delete();
        tq.delete();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain(input string name);
        wb_ready = 1'b1;
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
        chk(name, 64'(sb_q.size()), 64'h0);
        wb_ready = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: every handshake pops one expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1 && wb_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: popped tag %0d data %h, expected no entry", wb_tag, wb_data);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_tag", 64'(wb_tag), 64'(mon_e.tag));
                chk("sb_data", wb_data, mon_e.data);
                chk("sb_mask", 64'(wb_lane_mask), 64'(mon_e.mask));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [63:0] s_data [8];
    logic [3:0]  s_mask [8];

    initial begin
        s_data[0] = 64'h3f80_3f80_3f80_3f80; s_mask[0] = 4'b1111;
        s_data[1] = 64'h0000_3f80_0000_3f80; s_mask[1] = 4'b0101;
        s_data[2] = 64'h8000_8000_8000_8000; s_mask[2] = 4'b0000;
        s_data[3] = 64'h3f80_0000_0000_0000; s_mask[3] = 4'b1000;
        s_data[4] = 64'h0000_0000_0000_c000; s_mask[4] = 4'b0001;
        s_data[5] = 64'h4040_8000_0000_4040; s_mask[5] = 4'b1001;
        s_data[6] = 64'h0000_4000_4000_0000; s_mask[6] = 4'b0110;
        s_data[7] = 64'hbf80_bf80_8000_0000; s_mask[7] = 4'b1100;

        do_reset();

        // Single op, result three cycles after issue.
        issue(5'd3);
        tick();
        idle();
        tick();
        tick();
        result(64'h4000_c040_3f80_40e0, 4'b1111);
        chk("single_pre_valid", 64'(wb_valid), 64'h0);
        tick();
        idle();
        chk("single_valid", 64'(wb_valid), 64'h1);
        chk("single_tag", 64'(wb_tag), 64'd3);
        chk("single_data", wb_data, 64'h4000_c040_3f80_40e0);
        chk("single_mask", 64'(wb_lane_mask), 64'hf);
        chk("single_busy", 64'(busy), 64'h1);
        tick();
        chk("single_hold_tag", 64'(wb_tag), 64'd3);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("single_busy_after", 64'(busy), 64'h0);
        chk("single_valid_after", 64'(wb_valid), 64'h0);
        chk("single_data_zero", wb_data, 64'h0);

        // Signed and unsigned zero lanes.
        issue(5'd7);
        tick();
        idle();
        result(64'h4000_8000_3f80_0000, 4'b1010);
        tick();
        idle();
        chk("zero_mask", 64'(wb_lane_mask), 64'ha);
        drain("zero_drain");

        // Fill to capacity under backpressure.
        for (int i = 1; i <= 4; i++) begin
            issue(5'(i));
            tick();
        end
        idle();
        chk("full_issue_ready", 64'(issue_ready), 64'h0);
        chk("full_busy", 64'(busy), 64'h1);
        chk("full_err_clear", 64'(err), 64'h0);
        issue_en  = 1'b1;
        issue_tag = 5'd9;
        tick();
        idle();
        chk("full_illegal_err", 64'(err), 64'h1);
        result(64'h0000_0000_0000_0001, 4'b0001);
        tick();
        result(64'h8000_0000_0000_0000, 4'b0000);
        tick();
        result(64'hffff_0000_0000_0000, 4'b1000);
        tick();
        result(64'h0001_0002_8003_7fff, 4'b1111);
        tick();
        idle();
        chk("full_head_tag", 64'(wb_tag), 64'd1);
        wb_ready = 1'b1;
        chk("full_no_bypass", 64'(issue_ready), 64'h0);
        tick();
        chk("full_slot_freed", 64'(issue_ready), 64'h1);
        drain("full_drain");

        // Steady stream: issue, capture and pop in the same cycle.
        do_reset();
        wb_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            idle();
            if (c < 8) issue(5'(10 + c));
            if (c >= 2) result(s_data[c-2], s_mask[c-2]);
            tick();
            if (c >= 2 && c < 8) chk("stream_ready", 64'(issue_ready), 64'h1);
        end
        idle();
        drain("stream_drain");
        chk("stream_err", 64'(err), 64'h0);
        chk("stream_busy", 64'(busy), 64'h0);

        // Stray result with nothing outstanding.
        res_valid = 1'b1;
        res_data  = 64'h1234_5678_9abc_def0;
        tick();
        idle();
        chk("stray_err", 64'(err), 64'h1);
        chk("stray_valid", 64'(wb_valid), 64'h0);
        tick();
        chk("stray_valid_later", 64'(wb_valid), 64'h0);

        // Performance counters: 3 stall cycles then 2 writebacks.
        do_reset();
        issue(5'd20);
        tick();
        issue(5'd21);
        tick();
        idle();
        result(64'h3f80_0000_0000_0000, 4'b1000);
        tick();
        result(64'h0000_0000_0000_3f80, 4'b0001);
        tick();
        idle();
        tick();
        tick();
        wb_ready = 1'b1;
        tick();
        tick();
        wb_ready = 1'b0;
        chk("perf_drained", 64'(sb_q.size()), 64'h0);
`ifdef TENSOR_WB_PERF_EN
        chk("perf_stall", 64'(perf_stall_cnt), 64'd3);
        chk("perf_wb", 64'(perf_wb_cnt), 64'd2);
`else
        chk("perf_stall_off", 64'(perf_stall_cnt), 64'd0);
        chk("perf_wb_off", 64'(perf_wb_cnt), 64'd0);
`endif
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        chk("perf_clr_stall", 64'(perf_stall_cnt), 64'd0);
        chk("perf_clr_wb", 64'(perf_wb_cnt), 64'd0);

        chk("sb_empty_end", 64'(sb_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tensor_wb_buffer.md
Name: tensor_wb_buffer

Overview:
Writeback stage directly downstream of the 64-bit BFloat16 tensor MAC unit. The MAC unit carries no destination tag and cannot stall, so this block does three things:
- records each issued instruction's destination tag in issue order;
- pairs each tag with the next in-order MAC result (vector_out/valid_out) and buffers the pair;
- drains buffered results to the register-file write port over a valid/ready handshake.
Issue is throttled by credits so a result always has a buffer slot.

Parameters:
DEPTH, 4, buffer entries (power of 2, >=2); bounds issued-but-not-written-back instructions.
TAG_W, 5, destination register tag width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
issue_en  in  1  high in the same cycle the MAC unit's en is asserted
issue_tag  in  TAG_W  destination tag of the issuing instruction
issue_ready  out  1  issue permitted this cycle
res_valid  in  1  MAC unit valid_out
res_data  in  64  MAC unit vector_out, 4 BF16 lanes, lane i = bits [16i+15:16i]
wb_valid  out  1  writeback entry available
wb_ready  in  1  register-file port accepts the entry
wb_tag  out  TAG_W  destination tag of the head entry
wb_data  out  64  result data of the head entry
wb_lane_mask  out  4  bit i = lane i magnitude nonzero
busy  out  1  any entry issued and not yet written back
err  out  1  sticky protocol error
perf_clr  in  1  clears performance counters
perf_wb_cnt  out  32  completed writebacks
perf_stall_cnt  out  32  cycles with wb_valid && !wb_ready

Behaviour:
- Storage: DEPTH-entry circular array; each entry holds {tag, data, mask}.
- Pointers, each log2(DEPTH)+1 bits with wrap bit: iss_ptr, res_ptr, wb_ptr.
- Occupancy = iss_ptr - wb_ptr. Outstanding = iss_ptr - res_ptr. Ready = res_ptr - wb_ptr.
- Reset (asynchronous): pointers = 0, err = 0, counters = 0. Outputs read 0: issue_ready = 1, wb_valid = 0, busy = 0, wb_tag/wb_data/wb_lane_mask = 0. Array contents are don't-care.
- Reset mid-operation discards all entries. In-flight MAC results arriving after reset release take the stray-result path below.
- issue_ready = (occupancy != DEPTH). This is combinational from registers only; it never depends on issue_en.
- Issue: issue_en && issue_ready writes issue_tag into entry[iss_ptr] and increments iss_ptr.
- Illegal issue: issue_en && !issue_ready is ignored and sets err.
- Result capture: res_valid && outstanding != 0 writes res_data into entry[res_ptr] and computes the mask: bit i = OR of res_data[16i+14:16i], so -0.0 counts as zero. res_ptr then increments.
- Stray result: res_valid with outstanding == 0 is dropped and sets err.
- Results pair with tags strictly in issue order.
- wb_valid = (ready != 0). wb_tag/wb_data/wb_lane_mask are driven from entry[wb_ptr]; they are 0 when wb_valid = 0.
- Handshake: wb_valid && wb_ready pops the head (wb_ptr++).
- wb_valid, once high, stays high and the head is held stable until accepted.
- Latency: res_valid in cycle N gives wb_valid in cycle N+1 (empty-buffer case). Issue-to-writeback = MAC latency + 1.
- Simultaneous events, all in one cycle: issue, capture and pop operate on distinct pointers and all take effect. Occupancy changes by (+issue) - (pop).
- A capture and a pop of the same entry cannot coincide, because a pop needs ready != 0 beforehand.
- Full: occupancy == DEPTH, issue_ready = 0. A pop in that cycle frees a slot for the next cycle only; no same-cycle bypass.
- busy = (occupancy != 0).
- err clears only on reset.

Optional Feature:
Macro TENSOR_WB_PERF_EN.
- Defined: perf_wb_cnt increments per wb handshake. perf_stall_cnt increments per wb_valid && !wb_ready cycle. Both saturate at 32'hFFFFFFFF. perf_clr synchronously zeroes both and wins over an increment in the same cycle.
- Undefined: counter logic is absent, both outputs are tied to 0, and perf_clr is ignored.
- Ports exist in both builds.

Test Plan:
- Reset values: hold rst_n = 0 -> issue_ready = 1, wb_valid = 0, busy = 0, err = 0, wb_data = 0. Then release.
- Single op: issue tag 5'd3, then res_valid with res_data 64'h4000_c040_3f80_40e0 three cycles later -> next cycle wb_valid = 1, wb_tag = 3, wb_data = 64'h4000_c040_3f80_40e0, wb_lane_mask = 4'b1111. Then wb_ready = 1 -> busy = 0.
- Zero lanes: result 64'h4000_8000_3f80_0000 -> wb_lane_mask = 4'b1010 (-0.0 and +0.0 both masked).
- Full and backpressure: issue tags 1,2,3,4 with wb_ready = 0 -> issue_ready = 0 after the 4th issue. A 5th issue_en sets err. Return 4 results -> wb_tag pops 1,2,3,4 in order once wb_ready = 1.
- Simultaneous: steady stream with an issue, capture and pop in the same cycle -> occupancy constant, no err, tags match data order.
- Stray result: res_valid with nothing issued -> err = 1, wb_valid stays 0.
- With TENSOR_WB_PERF_EN: 3 stall cycles then 2 writebacks -> perf_stall_cnt = 3, perf_wb_cnt = 2. perf_clr -> both 0.
